// File: rtl/board_ram_pkg.sv
// Shared types and constants for the tic-tac-toe board/action RAM.
// Holds the clear-sweep FSM encoding, default geometry and the parity helper.
package board_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 256;

    // Even-parity bit: makes the total count of ones (word plus bit) even.
    function automatic logic evenParity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/board_ram_clear_ctrl.sv
// CLEAR/IDLE sequencer for board_ram: walks a pointer over every entry after
// reset or a clear request, and gates user accesses while it does so.
module board_ram_clear_ctrl
    import board_ram_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clearReq_i,
    output logic                 busy_o,
    output logic                 clrWe_o,
    output logic [PTR_WIDTH-1:0] clrAddr_o,
    output logic                 userEn_o
);

    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    state_e               state_q;
    logic [PTR_WIDTH-1:0] ptr_q;
    logic                 busy_q;

    // One entry is initialised per cycle; busy drops together with the move to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clearReq_i) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // A clear request in IDLE wins over any user access issued in the same cycle.
    assign busy_o    = busy_q;
    assign clrWe_o   = (state_q == ST_CLEAR);
    assign clrAddr_o = ptr_q;
    assign userEn_o  = (state_q == ST_IDLE) && !clearReq_i;

endmodule

// File: rtl/board_ram.sv
// One-write/one-read synchronous RAM with clear sweep, write-first bypass,
// read-valid strobe and range checking. Optional parity: BOARD_RAM_PARITY_EN.
module board_ram
    import board_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  d_valid,
    output logic                  addr_err
`ifdef BOARD_RAM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int                  IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  userEn;
    logic                  clrWe;
    logic [IDX_WIDTH-1:0]  clrAddr;
    logic [IDX_WIDTH-1:0]  wrIdx;
    logic [IDX_WIDTH-1:0]  rdIdx;
    logic                  wrInRange;
    logic                  rdInRange;
    logic                  wrFire;
    logic                  rdFire;
    logic                  bypass;

    logic [DATA_WIDTH-1:0] rdData_d, rdData_q;
    logic                  rdValid_d, rdValid_q;
    logic                  addrErr_d, addrErr_q;

    board_ram_clear_ctrl #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (IDX_WIDTH)
    ) u_clear_ctrl (
        .clock      (clock),
        .reset      (reset),
        .clearReq_i (clear_req),
        .busy_o     (busy),
        .clrWe_o    (clrWe),
        .clrAddr_o  (clrAddr),
        .userEn_o   (userEn)
    );

    assign wrIdx     = write_address[IDX_WIDTH-1:0];
    assign rdIdx     = read_address[IDX_WIDTH-1:0];
    assign wrInRange = {1'b0, write_address} < DEPTH_EXT;
    assign rdInRange = {1'b0, read_address} < DEPTH_EXT;
    assign wrFire    = userEn && write_enable && wrInRange;
    assign rdFire    = userEn && read_enable;
    assign bypass    = wrFire && rdInRange && (write_address == read_address);

    // Storage has no reset of its own; the sweep after reset initialises it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clrWe) begin
                mem[clrAddr] <= INIT_VALUE;
            end else if (wrFire) begin
                mem[wrIdx] <= d_in;
            end
        end
    end

    // Read data holds between reads; out-of-range reads return the clear value.
    always_comb begin
        rdData_d  = rdData_q;
        rdValid_d = rdFire;
        addrErr_d = userEn && ((write_enable && !wrInRange) || (read_enable && !rdInRange));
        if (rdFire) begin
            if (!rdInRange) begin
                rdData_d = INIT_VALUE;
            end else if (bypass) begin
                rdData_d = d_in;
            end else begin
                rdData_d = mem[rdIdx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
            addrErr_q <= 1'b0;
        end else begin
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
            addrErr_q <= addrErr_d;
        end
    end

    assign d_out    = rdData_q;
    assign d_valid  = rdValid_q;
    assign addr_err = addrErr_q;

`ifdef BOARD_RAM_PARITY_EN
    logic parMem [DEPTH];
    logic parErr_d, parErr_q;

    // Parity array mirrors the data array write-for-write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clrWe) begin
                parMem[clrAddr] <= evenParity(64'(INIT_VALUE));
            end else if (wrFire) begin
                parMem[wrIdx] <= evenParity(64'(d_in));
            end
        end
    end

    // Only reads served from the array can be checked; bypass data never was stored.
    assign parErr_d = rdFire && rdInRange && !bypass
                      && (parMem[rdIdx] != evenParity(64'(mem[rdIdx])));

    always_ff @(posedge clock) begin
        if (reset) begin
            parErr_q <= 1'b0;
        end else begin
            parErr_q <= parErr_d;
        end
    end

    assign parity_err = parErr_q;
`endif

endmodule

// File: tb/tb_board_ram.sv
// Self-checking bench for board_ram (DEPTH=9) against a cycle-level behavioural model.
// Also exercises the parity path when BOARD_RAM_PARITY_EN is defined.
module tb_board_ram;

    localparam int              DEPTH = 9;
    localparam logic [15:0]     INIT  = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        busy;
    logic        write_enable;
    logic [7:0]  write_address;
    logic [15:0] d_in;
    logic        read_enable;
    logic [7:0]  read_address;
    logic [15:0] d_out;
    logic        d_valid;
    logic        addr_err;
`ifdef BOARD_RAM_PARITY_EN
    logic        parity_err;
    logic        parBad [DEPTH];
    logic        expPar;
`endif

    int          checks   = 0;
    int          failures = 0;

    int          busyLeft;
    logic [15:0] modelMem [DEPTH];
    logic [15:0] expOut;
    logic        expValid;
    logic        expErr;

    board_ram #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (8),
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .clear_req     (clear_req),
        .busy          (busy),
        .write_enable  (write_enable),
        .write_address (write_address),
        .d_in          (d_in),
        .read_enable   (read_enable),
        .read_address  (read_address),
        .d_out         (d_out),
        .d_valid       (d_valid),
        .addr_err      (addr_err)
`ifdef BOARD_RAM_PARITY_EN
        ,
        .parity_err    (parity_err)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput();
        checks++;
        assert (busy === (busyLeft > 0)) else begin
            failures++;
            $error("FAIL busy observed=%0b expected=%0b", busy, (busyLeft > 0));
        end
        checks++;
        assert (d_valid === expValid) else begin
            failures++;
            $error("FAIL d_valid observed=%0b expected=%0b", d_valid, expValid);
        end
        checks++;
        assert (d_out === expOut) else begin
            failures++;
            $error("FAIL d_out observed=%h expected=%h", d_out, expOut);
        end
        checks++;
        assert (addr_err === expErr) else begin
            failures++;
            $error("FAIL addr_err observed=%0b expected=%0b", addr_err, expErr);
        end
`ifdef BOARD_RAM_PARITY_EN
        checks++;
        assert (parity_err === expPar) else begin
            failures++;
            $error("FAIL parity_err observed=%0b expected=%0b", parity_err, expPar);
        end
`endif
    endtask

    // Drive one cycle of inputs, advance the model by one clock, then check.
    task automatic applyStimulus(input logic rst, input logic clr, input logic we, input int wa,
                                 input logic [15:0] din, input logic re, input int ra);
        reset         = rst;
        clear_req     = clr;
        write_enable  = we;
        write_address = 8'(wa);
        d_in          = din;
        read_enable   = re;
        read_address  = 8'(ra);
`ifdef BOARD_RAM_PARITY_EN
        expPar = 1'b0;
`endif
        if (rst) begin
            busyLeft = DEPTH;
            expOut   = 16'h0000;
            expValid = 1'b0;
            expErr   = 1'b0;
        end else if (busyLeft > 0) begin
            modelMem[DEPTH - busyLeft] = INIT;
`ifdef BOARD_RAM_PARITY_EN
            parBad[DEPTH - busyLeft] = 1'b0;
`endif
            busyLeft--;
            expValid = 1'b0;
            expErr   = 1'b0;
        end else if (clr) begin
            busyLeft = DEPTH;
            expValid = 1'b0;
            expErr   = 1'b0;
        end else begin
            expErr   = (we && wa >= DEPTH) || (re && ra >= DEPTH);
            expValid = re;
            if (re) begin
                if (ra >= DEPTH) begin
                    expOut = INIT;
                end else if (we && wa == ra) begin
                    expOut = din;
                end else begin
                    expOut = modelMem[ra];
`ifdef BOARD_RAM_PARITY_EN
                    expPar = parBad[ra];
`endif
                end
            end
            if (we && wa < DEPTH) begin
                modelMem[wa] = din;
`ifdef BOARD_RAM_PARITY_EN
                parBad[wa] = 1'b0;
`endif
            end
        end
        @(posedge clock);
        #1;
        reset        = 1'b0;
        clear_req    = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        checkOutput();
    endtask

    initial begin
        reset         = 1'b1;
        clear_req     = 1'b0;
        write_enable  = 1'b0;
        write_address = '0;
        d_in          = '0;
        read_enable   = 1'b0;
        read_address  = '0;
        busyLeft      = 0;
        expOut        = '0;
        expValid      = 1'b0;
        expErr        = 1'b0;

        // Reset, then the sweep must take exactly DEPTH cycles.
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 16'h0, 0, 0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 16'h0, 1, i);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0);

        // Write then read back, and same-cycle write-first bypass.
        applyStimulus(0, 0, 1, 3, 16'hA5A5, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 3);
        applyStimulus(0, 0, 1, 5, 16'h1234, 1, 5);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0);
        applyStimulus(0, 0, 1, 7, 16'h7777, 1, 3);

        // Out-of-range read and write.
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 12);
        applyStimulus(0, 0, 1, 9, 16'hFFFF, 0, 0);
        applyStimulus(0, 0, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 16'h0, 1, i);

        // Fill, clear with a colliding write, accesses during busy, read back.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, i, 16'($urandom), 0, 0);
        applyStimulus(0, 1, 1, 2, 16'hBEEF, 1, 2);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, i, 16'($urandom), 1, i);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 16'h0, 1, i);

        // Reset part-way through a sweep restarts it.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, i, 16'($urandom), 0, 0);
        applyStimulus(0, 1, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 16'h0, 0, 0);
        applyStimulus(1, 0, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 0, 0, 16'h0, 1, i % DEPTH);

`ifdef BOARD_RAM_PARITY_EN
        // Corrupt a stored parity bit behind the design's back.
        applyStimulus(0, 0, 1, 1, 16'h0F0E, 0, 0);
        dut.parMem[1] = ~dut.parMem[1];
        parBad[1]     = 1'b1;
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 1, 1, 16'h1111, 1, 1);
        applyStimulus(0, 0, 0, 0, 16'h0, 1, 1);
`endif

        // Randomised traffic, including out-of-range addresses and rare clears/resets.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 16'($urandom),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
